// File: rtl/y_hist_reader_if.sv
// -----------------------------------------------------------------------------
// y_hist_reader_if
// Packet stream carrying histogram beats from y_hist_reader to its sink.
//   hist_data  : bin count of the current beat
//   hist_bin   : bin index of the current beat
//   hist_valid : beat valid
//   hist_ready : sink accepts the beat (driven by the sink)
//   hist_sop   : first beat of a sweep (bin 0)
//   hist_eop   : last beat of a sweep (last bin)
// Modports: master = beat source (the reader), slave = beat sink.
// -----------------------------------------------------------------------------
interface y_hist_reader_if #(
    parameter int CNT_W = 20,
    parameter int BIN_W = 8
);
    logic [CNT_W-1:0] hist_data;
    logic [BIN_W-1:0] hist_bin;
    logic             hist_valid;
    logic             hist_ready;
    logic             hist_sop;
    logic             hist_eop;

    modport master (
        output hist_data, hist_bin, hist_valid, hist_sop, hist_eop,
        input  hist_ready
    );

    modport slave (
        input  hist_data, hist_bin, hist_valid, hist_sop, hist_eop,
        output hist_ready
    );
endinterface

// File: rtl/y_hist_reader.sv
// -----------------------------------------------------------------------------
// y_hist_reader
// Sweeps the luma histogram bin RAM after every frame_sync pulse and streams
// each bin count as one beat of a ready/valid packet (sop on bin 0, eop on the
// last bin). Tracks the largest bin of each sweep.
//
// Optional build macro: Y_HIST_CLEAR_EN
//   defined   : every bin is written back to zero right after it is read
//               (one read + one write per bin, 1 beat every 2 cycles)
//   undefined : read-only sweep, 1 read per cycle, ram_wr/ram_wrdata tied 0
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   frame_sync        : end-of-frame pulse, starts a sweep when idle
//   ram_addr/rd/rddata: bin RAM read port (data valid the cycle after rd)
//   ram_wr/ram_wrdata : bin RAM write port (clear-on-read only)
//   hist              : beat stream, master side
//   busy              : sweep in progress
//   overrun           : sticky, frame_sync seen while busy
//   peak_bin/peak_cnt : largest bin of the last completed sweep
// -----------------------------------------------------------------------------
module y_hist_reader #(
    parameter int BINS  = 256,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_sync,
    output logic [7:0]       ram_addr,
    output logic             ram_rd,
    input  logic [CNT_W-1:0] ram_rddata,
    output logic             ram_wr,
    output logic [CNT_W-1:0] ram_wrdata,
    y_hist_reader_if.master  hist,
    output logic             busy,
    output logic             overrun,
    output logic [7:0]       peak_bin,
    output logic [CNT_W-1:0] peak_cnt
);

    localparam logic [7:0] LAST_BIN = 8'(BINS - 1);

`ifdef Y_HIST_CLEAR_EN
    typedef enum logic [1:0] {IDLE, RD, WR, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD, DRAIN} state_t;
`endif

    state_t           state_q;
    logic [7:0]       addr_q;
    logic             busy_q;
    logic             overrun_q;
    logic [7:0]       run_bin_q;
    logic [CNT_W-1:0] run_cnt_q;
    logic [7:0]       peak_bin_q;
    logic [CNT_W-1:0] peak_cnt_q;

    // Read issued last cycle: its data is on ram_rddata this cycle.
    logic             rd_pend_q;
    logic [7:0]       rd_bin_q;

    // Two-entry output FIFO, each entry tagged with its bin index.
    logic [CNT_W-1:0] fifo_data_q [2];
    logic [7:0]       fifo_bin_q  [2];
    logic [1:0]       fifo_cnt_q;
    logic [1:0]       fifo_cnt_d;
    logic             wr_ptr_q;
    logic             rd_ptr_q;

    logic             head_valid;
    logic             push;
    logic             pop;
    logic [2:0]       credits;
    logic             slot_free;
    logic             rd_fire;
    logic             drain_done;

    assign head_valid = (fifo_cnt_q != 2'd0);
    assign push       = rd_pend_q;
    assign pop        = head_valid & hist.hist_ready;
    assign fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

    // Slot accounting counts the FIFO after this cycle's pop plus the read
    // whose data lands at this edge. A read issued now lands one edge later,
    // so the FIFO can never exceed two entries even if the sink stalls, and
    // with the sink always ready a read can go out every cycle. ram_rd is
    // therefore decoded combinationally from the state and the pop.
    assign credits    = {1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, rd_pend_q};
    assign slot_free  = (credits < 3'd2);
    assign rd_fire    = (state_q == RD) & slot_free;

    // Sweep is finished once the last beat leaves at this edge and nothing
    // is left in the RAM pipeline.
    assign drain_done = ~rd_pend_q & (fifo_cnt_q == {1'b0, pop});

    // -------------------------------------------------------------------------
    // Control FSM and peak tracking
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            run_bin_q  <= '0;
            run_cnt_q  <= '0;
            peak_bin_q <= '0;
            peak_cnt_q <= '0;
        end else begin
            if (frame_sync && busy_q) begin
                overrun_q <= 1'b1;
            end

            // Strict compare keeps the lowest index on a tie.
            if (push && (ram_rddata > run_cnt_q)) begin
                run_cnt_q <= ram_rddata;
                run_bin_q <= rd_bin_q;
            end

            case (state_q)
                IDLE: begin
                    if (frame_sync) begin
                        addr_q    <= '0;
                        run_bin_q <= '0;
                        run_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RD;
                    end
                end
                RD: begin
                    if (rd_fire) begin
`ifdef Y_HIST_CLEAR_EN
                        state_q <= WR;
`else
                        if (addr_q == LAST_BIN) begin
                            state_q <= DRAIN;
                        end else begin
                            addr_q <= addr_q + 8'd1;
                        end
`endif
                    end
                end
`ifdef Y_HIST_CLEAR_EN
                WR: begin
                    if (addr_q == LAST_BIN) begin
                        state_q <= DRAIN;
                    end else begin
                        addr_q  <= addr_q + 8'd1;
                        state_q <= RD;
                    end
                end
`endif
                DRAIN: begin
                    if (drain_done) begin
                        peak_bin_q <= run_bin_q;
                        peak_cnt_q <= run_cnt_q;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline and output FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_bin_q   <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            rd_pend_q  <= rd_fire;
            rd_bin_q   <= addr_q;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= ram_rddata;
            fifo_bin_q[wr_ptr_q]  <= rd_bin_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ram_addr = addr_q;
    assign ram_rd   = rd_fire;

`ifdef Y_HIST_CLEAR_EN
    assign ram_wr     = (state_q == WR);
    assign ram_wrdata = '0;
`else
    assign ram_wr     = 1'b0;
    assign ram_wrdata = '0;
`endif

    assign hist.hist_valid = head_valid;
    assign hist.hist_data  = head_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign hist.hist_bin   = head_valid ? fifo_bin_q[rd_ptr_q]  : '0;
    assign hist.hist_sop   = head_valid & (fifo_bin_q[rd_ptr_q] == 8'd0);
    assign hist.hist_eop   = head_valid & (fifo_bin_q[rd_ptr_q] == LAST_BIN);

    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign peak_bin = peak_bin_q;
    assign peak_cnt = peak_cnt_q;

endmodule

// File: tb/tb_y_hist_reader.sv
// -----------------------------------------------------------------------------
// tb_y_hist_reader
// Scoreboard bench for y_hist_reader. A bin RAM model answers the DUT's read
// and write strobes; the expected beat list of each sweep is built from a
// separate reference copy of the histogram when frame_sync is issued, and a
// monitor pops and compares every accepted beat.
// Works with and without Y_HIST_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_y_hist_reader;
    localparam int BINS  = 256;
    localparam int CNT_W = 20;
`ifdef Y_HIST_CLEAR_EN
    localparam bit CLEAR   = 1'b1;
    localparam int EOP_LAT = 513;
`else
    localparam bit CLEAR   = 1'b0;
    localparam int EOP_LAT = 258;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             frame_sync = 1'b0;
    logic [7:0]       ram_addr;
    logic             ram_rd;
    logic [CNT_W-1:0] ram_rddata = '0;
    logic             ram_wr;
    logic [CNT_W-1:0] ram_wrdata;
    logic             busy;
    logic             overrun;
    logic [7:0]       peak_bin;
    logic [CNT_W-1:0] peak_cnt;

    y_hist_reader_if #(.CNT_W(CNT_W), .BIN_W(8)) hist_if ();

    y_hist_reader #(.BINS(BINS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_sync (frame_sync),
        .ram_addr   (ram_addr),
        .ram_rd     (ram_rd),
        .ram_rddata (ram_rddata),
        .ram_wr     (ram_wr),
        .ram_wrdata (ram_wrdata),
        .hist       (hist_if),
        .busy       (busy),
        .overrun    (overrun),
        .peak_bin   (peak_bin),
        .peak_cnt   (peak_cnt)
    );

    always #5 clk = ~clk;

    // Bin RAM model: registered read, data valid the cycle after ram_rd.
    logic [CNT_W-1:0] ram_mem [BINS];
    // Reference histogram the expected beats are taken from.
    logic [CNT_W-1:0] ref_mem [BINS];

    always @(posedge clk) begin
        if (ram_rd) ram_rddata <= ram_mem[ram_addr];
        if (ram_wr) ram_mem[ram_addr] <= ram_wrdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [7:0]       bin;
        logic [CNT_W-1:0] data;
    } beat_t;

    beat_t            exp_q[$];
    int               beats_seen = 0;
    int               base_beats = 0;
    int               sop_cyc = -1;
    int               eop_cyc = -1;
    bit               rand_ready = 1'b0;
    logic [7:0]       exp_pbin = '0;
    logic [CNT_W-1:0] exp_pcnt = '0;

    // Sink ready, changed just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rand_ready) hist_if.hist_ready = 1'($urandom_range(0, 1));
        else            hist_if.hist_ready = 1'b1;
    end

    // Monitor: samples on the falling edge.
    logic        prev_stall = 1'b0;
    logic [28:0] prev_word  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold",
                      64'({hist_if.hist_valid, hist_if.hist_bin, hist_if.hist_data}),
                      64'(prev_word));
            end
            if (ram_rd || ram_wr) begin
                check("rd_wr_exclusive", 64'(ram_rd & ram_wr), 64'(0));
            end
            if (hist_if.hist_valid && hist_if.hist_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'(1), 64'(0));
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat",
                          64'({hist_if.hist_sop, hist_if.hist_eop, hist_if.hist_bin, hist_if.hist_data}),
                          64'(e));
                end
                beats_seen++;
                if (hist_if.hist_sop) sop_cyc = cyc;
                if (hist_if.hist_eop) eop_cyc = cyc;
            end
            prev_stall = hist_if.hist_valid & ~hist_if.hist_ready;
            prev_word  = {hist_if.hist_valid, hist_if.hist_bin, hist_if.hist_data};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_ramp();
        for (int i = 0; i < BINS; i++) begin
            ram_mem[i] = 20'(i);
            ref_mem[i] = 20'(i);
        end
    endtask

    task automatic load_peak();
        for (int i = 0; i < BINS; i++) begin
            ram_mem[i] = 20'd5;
            ref_mem[i] = 20'd5;
        end
        ram_mem[7]   = 20'hFFFFF; ref_mem[7]   = 20'hFFFFF;
        ram_mem[200] = 20'hFFFFF; ref_mem[200] = 20'hFFFFF;
    endtask

    task automatic load_random();
        for (int i = 0; i < BINS; i++) begin
            ram_mem[i] = 20'($urandom);
            ref_mem[i] = ram_mem[i];
        end
    endtask

    // Queue the whole expected sweep, then pulse frame_sync (cycle 0 = start).
    task automatic start_sweep(output int start);
        logic [7:0]       pb;
        logic [CNT_W-1:0] pc;
        pb = '0;
        pc = '0;
        for (int i = 0; i < BINS; i++) begin
            beat_t e;
            e.sop  = (i == 0);
            e.eop  = (i == BINS - 1);
            e.bin  = 8'(i);
            e.data = ref_mem[i];
            exp_q.push_back(e);
            if (ref_mem[i] > pc) begin
                pc = ref_mem[i];
                pb = 8'(i);
            end
            if (CLEAR) ref_mem[i] = '0;
        end
        exp_pbin   = pb;
        exp_pcnt   = pc;
        sop_cyc    = -1;
        eop_cyc    = -1;
        base_beats = beats_seen;
        frame_sync = 1'b1;
        start      = cyc;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic finish_sweep(input string tag, input int limit, output int fall);
        fall = -1;
        for (int k = 0; k < limit && fall < 0; k++) begin
            if (!busy) fall = cyc;
            else       tick();
        end
        if (fall < 0) check({tag, "_timeout"}, 64'(1), 64'(0));
        check({tag, "_peak_bin"}, 64'(peak_bin), 64'(exp_pbin));
        check({tag, "_peak_cnt"}, 64'(peak_cnt), 64'(exp_pcnt));
        check({tag, "_beats"}, 64'(beats_seen - base_beats), 64'(BINS));
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_ram(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < BINS; i++) begin
            if (ram_mem[i] !== ref_mem[i]) diff++;
        end
        check({tag, "_ram_contents"}, 64'(diff), 64'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ram_ctl"}, 64'({ram_rd, ram_wr, ram_addr}), 64'(0));
        check({tag, "_ram_wrdata"}, 64'(ram_wrdata), 64'(0));
        check({tag, "_hist_ctl"},
              64'({hist_if.hist_valid, hist_if.hist_sop, hist_if.hist_eop, hist_if.hist_bin}), 64'(0));
        check({tag, "_hist_data"}, 64'(hist_if.hist_data), 64'(0));
        check({tag, "_status"}, 64'({busy, overrun}), 64'(0));
        check({tag, "_peak_bin"}, 64'(peak_bin), 64'(0));
        check({tag, "_peak_cnt"}, 64'(peak_cnt), 64'(0));
    endtask

    task automatic wait_beats(input string tag, input int n);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 4000 && !hit; k++) begin
            if (beats_seen - base_beats >= n) hit = 1'b1;
            else                              tick();
        end
        if (!hit) check({tag, "_wait_beats"}, 64'(beats_seen - base_beats), 64'(n));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s;
        int f;
        hist_if.hist_ready = 1'b1;
        for (int i = 0; i < BINS; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // Ramp, sink always ready: latency and throughput.
        load_ramp();
        start_sweep(s);
        check("t1_busy_rise", 64'(busy), 64'(1));
        finish_sweep("t1", 2000, f);
        check("t1_sop_cycle", 64'(sop_cyc - s), 64'(3));
        check("t1_eop_cycle", 64'(eop_cyc - s), 64'(EOP_LAT));
        check("t1_busy_fall", 64'(f - s), 64'(EOP_LAT + 1));
        check_ram("t1");

        // Second sweep on the same RAM: zeros when clearing, ramp otherwise.
        start_sweep(s);
        finish_sweep("t1b", 2000, f);
        check_ram("t1b");

        // Ramp with a randomly stalling sink.
        load_ramp();
        rand_ready = 1'b1;
        start_sweep(s);
        finish_sweep("t2", 8000, f);
        rand_ready = 1'b0;
        tick();

        // Tied peaks at full scale: lowest index wins.
        load_peak();
        start_sweep(s);
        finish_sweep("t3", 2000, f);
        check_ram("t3");

        // frame_sync during a sweep: sticky overrun, no restart.
        check("t4_overrun_pre", 64'(overrun), 64'(0));
        load_random();
        start_sweep(s);
        wait_beats("t4", 100);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("t4_overrun_set", 64'(overrun), 64'(1));
        finish_sweep("t4", 2000, f);
        repeat (20) tick();
        check("t4_no_restart", 64'({busy, hist_if.hist_valid}), 64'(0));
        check("t4_beats_after", 64'(beats_seen - base_beats), 64'(BINS));
        check("t4_overrun_sticky", 64'(overrun), 64'(1));

        // Reset in the middle of a sweep, then a full fresh sweep.
        load_random();
        start_sweep(s);
        wait_beats("t5", 50);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check_zero("t5_rst");
        tick();
        load_random();
        start_sweep(s);
        finish_sweep("t5", 2000, f);
        check("t5_sop_cycle", 64'(sop_cyc - s), 64'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/y_hist_reader.md
# y_hist_reader

Reads out the 256-bin luma histogram that the histogram builder accumulates in the shared bin RAM.
- On every `frame_sync` pulse, sweeps bins 0..255 and streams each 20-bit count on a ready/valid packet interface with `sop`/`eop`.
- Optionally clears each bin as it is read, so the RAM starts the next frame at zero.
- Runs in the inter-frame gap, on the RAM port the builder leaves idle between frames; also reports the peak bin of each sweep.

## Interface

Parameters:
- `BINS`, 256: number of bins swept (address range `0..BINS-1`).
- `CNT_W`, 20: bin count width; matches the RAM data width.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `frame_sync`, in, 1: one-cycle end-of-frame pulse from the histogram builder; starts a sweep.
- `ram_addr`, out, 8: bin RAM address.
- `ram_rd`, out, 1: read strobe; `ram_rddata` is valid on the cycle after `ram_rd`.
- `ram_rddata`, in, 20: bin RAM read data.
- `ram_wr`, out, 1: write strobe.
- `ram_wrdata`, out, 20: bin RAM write data (always 0).
- `hist_data`, out, 20: bin count.
- `hist_bin`, out, 8: bin index of the current beat.
- `hist_valid`, out, 1: beat valid.
- `hist_ready`, in, 1: sink accepts the beat.
- `hist_sop`, out, 1: first beat (bin 0).
- `hist_eop`, out, 1: last beat (bin `BINS-1`).
- `busy`, out, 1: sweep in progress.
- `overrun`, out, 1: sticky flag; a `frame_sync` arrived while `busy`.
- `peak_bin`, out, 8: index of the largest bin of the last completed sweep.
- `peak_cnt`, out, 20: count of the largest bin of the last completed sweep.

## Operation

FSM states: IDLE, RD, WR, DRAIN.

- **IDLE:** `frame_sync=1` loads the address counter with 0, clears the peak trackers, sets `busy`, and goes to RD.
- **RD:** issues `ram_rd` at the current address only if a slot is free, i.e. (output FIFO occupancy + reads in flight) < 2. Otherwise it stays in RD with `ram_rd=0`.
  - After a read with `Y_HIST_CLEAR_EN` compiled in: go to WR.
  - After a read without it: advance the address; after address `BINS-1`, go to DRAIN.
- **WR:** drives `ram_wr=1`, `ram_wrdata=0`, with `ram_addr` held at the address just read. Then advance the address; go to RD, or to DRAIN after address `BINS-1`.
- **DRAIN:** waits until the FIFO is empty and no read is in flight. Then it latches the peak outputs, clears `busy`, and returns to IDLE.

Datapath:
- Returned read data enters a 2-entry output FIFO tagged with its bin index. `sop` = (index == 0); `eop` = (index == `BINS-1`).
- A beat transfers when `hist_valid & hist_ready`. When `hist_ready` is low the outputs hold stable; no beat is dropped or duplicated.
- The peak tracker compares each returned count with the running maximum using strict `>`, so the lowest index wins a tie. With an all-zero histogram, `peak_bin=0` and `peak_cnt=0`.

Boundary and error cases:
- `frame_sync` while `busy`: ignored and sets `overrun`. `overrun` is cleared only by `rst`.
- A count of `0xFFFFF` passes through unchanged; there is no arithmetic on the data path.
- `ram_rd` and `ram_wr` are never asserted in the same cycle.

Reset: `rst` mid-sweep aborts immediately and returns to IDLE with the FIFO emptied. Every output resets to 0: `ram_rd`, `ram_wr`, `ram_addr`, `ram_wrdata`, `hist_valid`, `hist_sop`, `hist_eop`, `hist_data`, `hist_bin`, `busy`, `overrun`, `peak_bin`, `peak_cnt`. Bins not yet cleared keep their values.

## Timing

- `frame_sync` high in cycle 0: first `ram_rd` (addr 0) in cycle 1, data captured at the end of cycle 2, `hist_valid` with `hist_sop` from cycle 3.
- Throughput with `hist_ready` held at 1:
  - Without clear: 1 beat/cycle, `eop` beat in cycle 258.
  - With clear: 1 beat per 2 cycles, `eop` beat in cycle 513.
- `busy` rises in cycle 1 and falls the cycle after the `eop` beat transfers.
- The peak outputs update in the same cycle `busy` falls.
- `frame_sync` is accepted again from the cycle `busy` is 0.

## Configuration

`Y_HIST_CLEAR_EN`:
- **Defined:** the WR state is compiled in and every bin is zeroed immediately after it is read.
- **Undefined:** no WR state; `ram_wr` and `ram_wrdata` are tied to 0, the histogram accumulates across frames, and the sweep runs at 1 read/cycle.

## Test plan

- RAM preloaded with bin[i]=i, `hist_ready`=1, one `frame_sync` → 256 beats with data 0..255, `sop` on bin 0, `eop` on bin 255; `peak_bin`=255, `peak_cnt`=255.
- Same preload, `hist_ready` toggling randomly 50% → identical beat sequence, outputs stable while stalled, no gaps in `hist_bin`.
- With `Y_HIST_CLEAR_EN`: after the sweep, all 256 RAM words = 0; a second sweep returns 256 zeros with `peak_bin`=0.
- bin[7]=bin[200]=0xFFFFF, all others 5 → `peak_bin`=7, `peak_cnt`=0xFFFFF.
- Second `frame_sync` at beat 100 → `overrun`=1, sweep completes normally with 256 beats, no restart.
- `rst` at beat 50 → all outputs 0 the next cycle; a new `frame_sync` produces a full sweep starting at bin 0.
